// File: rtl/dino_pkg.sv
// Shared types and constants for the dino game / Q-learning bot datapath.
package dino_pkg;

  localparam int unsigned NUM_SECTOR = 32;
  localparam int unsigned NUM_CACTUS = 4;
  localparam int unsigned DIST_W     = 10;
  localparam int unsigned CACTUS_W   = 3;

  typedef enum logic [1:0] {
    R_NONE      = 2'd0,
    R_GOOD_JUMP = 2'd1,
    R_BAD_STAY  = 2'd2,
    R_BAD_JUMP  = 2'd3
  } reward_t;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_AIRBORNE = 2'd1,
    S_REPORT   = 2'd2,
    S_DEAD     = 2'd3
  } track_state_t;

  // Out-of-range cactus types fold onto the last table column.
  function automatic logic [CACTUS_W-1:0] clamp_cactus(input logic [CACTUS_W-1:0] c,
                                                      input int unsigned n);
    if (32'(c) >= n) return CACTUS_W'(n - 1);
    return c;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at MAX instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 8,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/jump_outcome_tracker.sv
// Turns bot predictions into jump commands and reports each decision's outcome
// (reward code plus the snapshotted table index) back to the bot.
module jump_outcome_tracker
  import dino_pkg::*;
#(
  parameter int unsigned MAX_AIR_TICKS = 40,
  parameter int unsigned NUM_CACTUS    = dino_pkg::NUM_CACTUS,
  parameter int unsigned SCORE_W       = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                game_tick,
  input  logic                prediction,
  input  logic [DIST_W-1:0]   distance,
  input  logic [CACTUS_W-1:0] cactus,
  input  logic                airborne,
  input  logic                collision,
  input  logic                cactus_passed,
  input  logic                game_restart,
  output logic                jump_cmd,
  output logic [1:0]          state,
  output logic [DIST_W-1:0]   jump_distance,
  output logic [CACTUS_W-1:0] jump_cactus,
  output logic [SCORE_W-1:0]  score,
  output logic                dead
);

  localparam int unsigned AIR_W = $clog2(MAX_AIR_TICKS + 1);
  localparam logic [AIR_W-1:0] AIR_MAX = AIR_W'(MAX_AIR_TICKS);

  track_state_t        fsm;
  track_state_t        after_report;
  logic [DIST_W-1:0]   jump_snap_dist;
  logic [CACTUS_W-1:0] jump_snap_cactus;
  logic [DIST_W-1:0]   stay_snap_dist;
  logic [CACTUS_W-1:0] stay_snap_cactus;
  logic                airborne_q;
  logic [AIR_W-1:0]    air_count;
  logic [CACTUS_W-1:0] cactus_clamped;
  logic                score_inc;
  logic                score_clr;
  logic                air_inc;
  logic                air_clr;
  logic                air_done;

  assign cactus_clamped = clamp_cactus(cactus, NUM_CACTUS);

  // A pass that coincides with a collision never counts.
  assign score_inc = ((fsm == S_IDLE) || (fsm == S_AIRBORNE)) && cactus_passed && !collision;
  assign score_clr = (fsm == S_DEAD) && game_restart;
  assign air_inc   = (fsm == S_AIRBORNE) && game_tick;
  assign air_clr   = (fsm != S_AIRBORNE);

  // Landing is a falling edge of airborne; the jump cycle itself starts grounded.
  assign air_done = (air_count == AIR_MAX) || (airborne_q && !airborne);

  sat_counter #(
    .W   (SCORE_W),
    .MAX ({SCORE_W{1'b1}})
  ) u_score (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (score_clr),
    .inc   (score_inc),
    .count (score)
  );

  sat_counter #(
    .W   (AIR_W),
    .MAX (AIR_MAX)
  ) u_air (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (air_clr),
    .inc   (air_inc),
    .count (air_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm              <= S_IDLE;
      after_report     <= S_IDLE;
      jump_snap_dist   <= '0;
      jump_snap_cactus <= '0;
      stay_snap_dist   <= '0;
      stay_snap_cactus <= '0;
      airborne_q       <= 1'b0;
      jump_cmd         <= 1'b0;
      state            <= R_NONE;
      jump_distance    <= '0;
      jump_cactus      <= '0;
      dead             <= 1'b0;
    end else begin
      jump_cmd   <= 1'b0;
      state      <= R_NONE;
      airborne_q <= airborne;
      case (fsm)
        S_IDLE: begin
          if (collision) begin
            state         <= R_BAD_STAY;
            jump_distance <= stay_snap_dist;
            jump_cactus   <= stay_snap_cactus;
            after_report  <= S_DEAD;
            fsm           <= S_REPORT;
          end else if (game_tick && !airborne) begin
            if (prediction) begin
              jump_snap_dist   <= distance;
              jump_snap_cactus <= cactus_clamped;
              jump_cmd         <= 1'b1;
              fsm              <= S_AIRBORNE;
            end else begin
              stay_snap_dist   <= distance;
              stay_snap_cactus <= cactus_clamped;
            end
          end
        end
        S_AIRBORNE: begin
          if (collision) begin
            state         <= R_BAD_JUMP;
            jump_distance <= jump_snap_dist;
            jump_cactus   <= jump_snap_cactus;
            after_report  <= S_DEAD;
            fsm           <= S_REPORT;
          end else if (cactus_passed) begin
            state         <= R_GOOD_JUMP;
            jump_distance <= jump_snap_dist;
            jump_cactus   <= jump_snap_cactus;
            after_report  <= S_IDLE;
            fsm           <= S_REPORT;
          end else if (air_done) begin
            fsm <= S_IDLE;
          end
        end
        S_REPORT: begin
          fsm  <= after_report;
          dead <= (after_report == S_DEAD);
        end
        S_DEAD: begin
          if (game_restart) begin
            dead <= 1'b0;
            fsm  <= S_IDLE;
          end
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end

endmodule
